// File: rtl/nn_pkg.sv
// Shared types and width helpers for the layer sequencer and its address generator.
package nn_pkg;

    localparam int RESULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        WAIT,
        DONE
    } state_t;

    // Address width for a memory of 'depth' words, never narrower than one bit.
    function automatic int aw(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/nls_addr_gen.sv
// Input/neuron counters and memory addresses; addresses are valid in the same cycle they are issued.
// Never stalls; step_i/step_n advance the counters and clr returns them to zero.
module nls_addr_gen
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clr,
    input  logic                                    step_i,
    input  logic                                    step_n,
    output logic                                    last_i,
    output logic                                    last_n,
    output logic [aw(NUM_INPUTS)-1:0]               in_addr,
    output logic [aw(NUM_INPUTS*NUM_NEURONS)-1:0]   w_addr,
    output logic [aw(NUM_NEURONS)-1:0]              b_addr
);

    localparam int IAW = aw(NUM_INPUTS);
    localparam int WAW = aw(NUM_INPUTS * NUM_NEURONS);
    localparam int BAW = aw(NUM_NEURONS);

    logic [IAW-1:0] i;
    logic [BAW-1:0] n;
    logic [WAW-1:0] base;

    // base tracks n*NUM_INPUTS by accumulation, so no multiplier is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i    <= '0;
            n    <= '0;
            base <= '0;
        end else if (clr) begin
            i    <= '0;
            n    <= '0;
            base <= '0;
        end else begin
            if (step_i) begin
                i <= last_i ? '0 : i + IAW'(1);
            end
            if (step_n) begin
                n    <= n + BAW'(1);
                base <= base + WAW'(NUM_INPUTS);
            end
        end
    end

    assign last_i  = (i == IAW'(NUM_INPUTS - 1));
    assign last_n  = (n == BAW'(NUM_NEURONS - 1));
    assign in_addr = i;
    assign b_addr  = n;
    assign w_addr  = base + WAW'(i);

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Runs one shared MAC neuron over every output of a layer; neuron n's result is written 2+(n+1)(N+2) cycles after start.
// No backpressure: memories answer in one cycle, the only stall is WAIT, bounded by TIMEOUT.
module neuron_layer_sequencer
    import nn_pkg::*;
#(
    parameter int IN_WIDTH    = 16,
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 32,
    parameter int TIMEOUT     = 15
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    abort,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err,
    output logic [aw(NUM_INPUTS)-1:0]               in_addr,
    input  logic [IN_WIDTH-1:0]                     in_rdata,
    output logic [aw(NUM_INPUTS*NUM_NEURONS)-1:0]   w_addr,
    input  logic [IN_WIDTH-1:0]                     w_rdata,
    output logic [aw(NUM_NEURONS)-1:0]              b_addr,
    input  logic [IN_WIDTH-1:0]                     b_rdata,
    output logic                                    nrn_rst,
    output logic [IN_WIDTH-1:0]                     nrn_data,
    output logic [IN_WIDTH-1:0]                     nrn_weight,
    output logic [IN_WIDTH-1:0]                     nrn_bias,
    output logic                                    nrn_valid,
    input  logic [RESULT_WIDTH-1:0]                 nrn_out,
    input  logic                                    nrn_out_valid,
    output logic                                    res_we,
    output logic [aw(NUM_NEURONS)-1:0]              res_addr,
    output logic [RESULT_WIDTH-1:0]                 res_data
);

    localparam int TCW = aw(TIMEOUT + 1);

    state_t         state, state_n;
    logic [TCW-1:0] wait_cnt;
    logic           step_i, step_n, last_i, last_n, timeout;
    logic           accept, kill, wr;

    assign accept = (state == IDLE) && start;
    assign kill   = (state != IDLE) && abort;
    assign wr     = (state == WAIT) && nrn_out_valid && !abort;

    nls_addr_gen #(
        .NUM_INPUTS  (NUM_INPUTS),
        .NUM_NEURONS (NUM_NEURONS)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_n == IDLE),
        .step_i  (step_i),
        .step_n  (step_n),
        .last_i  (last_i),
        .last_n  (last_n),
        .in_addr (in_addr),
        .w_addr  (w_addr),
        .b_addr  (b_addr)
    );

    always_comb begin
        state_n = state;
        step_i  = 1'b0;
        step_n  = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE:   if (start) state_n = CLEAR;
            CLEAR:  state_n = STREAM;
            STREAM: begin
                step_i = 1'b1;
                if (last_i) state_n = WAIT;
            end
            WAIT: begin
                if (nrn_out_valid) begin
                    if (last_n) begin
                        state_n = DONE;
                    end else begin
                        step_n  = 1'b1;
                        state_n = STREAM;
                    end
                end else if (wait_cnt == TCW'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort overrides every other decision once the layer is running
        if (kill) begin
            state_n = IDLE;
            step_i  = 1'b0;
            step_n  = 1'b0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            nrn_valid <= 1'b0;
            nrn_rst   <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= (state == WAIT) ? wait_cnt + TCW'(1) : '0;
            // one-cycle memory latency: valid trails the read issue by one register
            nrn_valid <= (state == STREAM) && !abort;
            nrn_rst   <= accept || kill || timeout;
            res_we    <= wr;
            if (wr) begin
                res_addr <= b_addr;
                res_data <= nrn_out;
            end
            if (accept)       err <= 1'b0;
            else if (timeout) err <= 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign nrn_data   = in_rdata;
    assign nrn_weight = w_rdata;
    assign nrn_bias   = b_rdata;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with ROM and neuron models and a result scoreboard.
module tb_neuron_layer_sequencer;

    localparam int N   = 4;
    localparam int M   = 3;
    localparam int TO  = 6;
    localparam int IAW = $clog2(N);
    localparam int WAW = $clog2(N * M);
    localparam int BAW = $clog2(M);
    localparam int LAST = M * (N + 2) + 2;

    logic           clk = 1'b0;
    logic           rst, start, abort;
    logic           busy, done, err;
    logic [IAW-1:0] in_addr;
    logic [WAW-1:0] w_addr;
    logic [BAW-1:0] b_addr, res_addr;
    logic [15:0]    in_rdata, w_rdata, b_rdata;
    logic           nrn_rst, nrn_valid, nrn_out_valid, res_we;
    logic [15:0]    nrn_data, nrn_weight, nrn_bias, nrn_out, res_data;

    logic           stub_dead = 1'b0;
    logic           spur = 1'b0;
    logic [15:0]    acc;
    int             beats;
    logic           ov;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int writes = 0;
    int sb_addr[$];
    int sb_data[$];
    int sb_cyc[$];

    neuron_layer_sequencer #(
        .IN_WIDTH(16), .NUM_INPUTS(N), .NUM_NEURONS(M), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .in_addr(in_addr), .in_rdata(in_rdata),
        .w_addr(w_addr), .w_rdata(w_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .nrn_rst(nrn_rst), .nrn_data(nrn_data), .nrn_weight(nrn_weight), .nrn_bias(nrn_bias),
        .nrn_valid(nrn_valid), .nrn_out(nrn_out), .nrn_out_valid(nrn_out_valid),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // synchronous memories: activation i+1, weight addr+1, bias 100+n
    always @(posedge clk) begin
        in_rdata <= 16'(in_addr) + 16'd1;
        w_rdata  <= 16'(w_addr) + 16'd1;
        b_rdata  <= 16'(b_addr) + 16'd100;
    end

    // neuron: N-beat MAC, result one cycle after the final beat
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0; beats <= 0; ov <= 1'b0; nrn_out <= '0;
        end else begin
            ov <= 1'b0;
            if (nrn_rst) begin
                acc <= '0; beats <= 0;
            end else if (nrn_valid) begin
                if (beats == N - 1) begin
                    nrn_out <= acc + nrn_data * nrn_weight + nrn_bias;
                    ov      <= !stub_dead;
                    acc     <= '0;
                    beats   <= 0;
                end else begin
                    acc   <= acc + nrn_data * nrn_weight;
                    beats <= beats + 1;
                end
            end
        end
    end
    assign nrn_out_valid = ov | spur;

    function automatic int exp_res(input int n);
        int s;
        s = 100 + n;
        for (int i = 0; i < N; i++) s += (i + 1) * (n * N + i + 1);
        return s & 32'hffff;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int n);
        sb_addr.push_back(n);
        sb_data.push_back(exp_res(n));
        sb_cyc.push_back(2 + (n + 1) * (N + 2));
    endtask

    task automatic tick();
        int ea, ed, ec;
        @(posedge clk);
        #1;
        cyc++;
        if (res_we) begin
            writes++;
            chk("write_expected", 32'(sb_addr.size() != 0), 32'(1));
            if (sb_addr.size() != 0) begin
                ea = sb_addr.pop_front();
                ed = sb_data.pop_front();
                ec = sb_cyc.pop_front();
                chk("res_addr", 32'(res_addr), ea);
                chk("res_data", 32'(res_data), ed);
                chk("res_cycle", cyc, ec);
            end
        end
    endtask

    task automatic run_layer(input bit disturb);
        int k, nn;
        for (int n = 0; n < M; n++) push_exp(n);
        writes = 0;
        start = 1'b1;
        abort = disturb;
        cyc = 0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("clear_nrn_rst", 32'(nrn_rst), 1);
        chk("clear_busy", 32'(busy), 1);
        chk("err_cleared", 32'(err), 0);
        for (int c = 2; c <= LAST + 1; c++) begin
            if (disturb) begin
                spur  = (c == 3 || c == 4);
                start = (c == 4);
            end
            tick();
            k  = (c - 2) % (N + 2);
            nn = (c - 2) / (N + 2);
            chk("done", 32'(done), 32'(c == LAST));
            chk("busy", 32'(busy), 32'(c <= LAST));
            chk("nrn_rst_quiet", 32'(nrn_rst), 0);
            chk("nrn_valid", 32'(nrn_valid), 32'(c < LAST && k >= 1 && k <= N));
            if (c < LAST) begin
                chk("b_addr", 32'(b_addr), nn);
                if (k < N) begin
                    chk("in_addr", 32'(in_addr), k);
                    chk("w_addr", 32'(w_addr), nn * N + k);
                end
                if (k == N) chk("final_bias", 32'(nrn_bias), 100 + nn);
            end
        end
        spur  = 1'b0;
        start = 1'b0;
        chk("write_count", writes, M);
        chk("scoreboard_empty", sb_addr.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_nrn_rst", 32'(nrn_rst), 0);
        chk("rst_nrn_valid", 32'(nrn_valid), 0);
        chk("rst_res_we", 32'(res_we), 0);
        chk("rst_addrs", {in_addr, w_addr, b_addr, res_addr}, 0);
        chk("rst_res_data", 32'(res_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_nrn_rst", 32'(nrn_rst), 0);

        run_layer(1'b0);

        // abort during neuron 1 STREAM
        push_exp(0);
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_nrn_rst", 32'(nrn_rst), 1);
        chk("abort_nrn_valid", 32'(nrn_valid), 0);
        chk("abort_res_we", 32'(res_we), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_err", 32'(err), 0);
        tick();
        chk("abort_rst_pulse", 32'(nrn_rst), 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
        end
        chk("abort_sb_empty", sb_addr.size(), 0);
        run_layer(1'b0);

        // neuron never answers: timeout
        stub_dead = 1'b1;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        for (int c = 2; c <= N + 2 + TO + 1; c++) begin
            tick();
            if (c <= N + 2 + TO) begin
                chk("to_busy", 32'(busy), 1);
                chk("to_err_low", 32'(err), 0);
            end else begin
                chk("to_err", 32'(err), 1);
                chk("to_idle", 32'(busy), 0);
                chk("to_nrn_rst", 32'(nrn_rst), 1);
                chk("to_done", 32'(done), 0);
            end
        end
        tick();
        chk("to_err_sticky", 32'(err), 1);
        stub_dead = 1'b0;
        run_layer(1'b0);

        // start+abort together in IDLE, start while busy, spurious out_valid
        run_layer(1'b1);

        // asynchronous reset mid-STREAM
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_arst_valid", 32'(nrn_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_nrn_valid", 32'(nrn_valid), 0);
        chk("arst_addrs", {in_addr, w_addr, b_addr}, 0);
        chk("arst_misc", {nrn_rst, res_we, done, err}, 0);
        #2;
        rst = 1'b0;
        tick();
        chk("arst_stays_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
- Time-multiplexes one shared neuron MAC unit across NUM_NEURONS outputs of a fully connected layer.
- For each output it streams NUM_INPUTS activation/weight pairs from synchronous ROM/RAM into the neuron, with that neuron's bias.
- Captures the neuron result and writes it to the layer result buffer.
- Sits between the top-level inference FSM (start/done) and the neuron + memories.

Parameters:
- IN_WIDTH, 16, activation/weight/bias word width
- NUM_INPUTS, 784, MAC beats per output; must equal the neuron's NUM_INPUTS
- NUM_NEURONS, 32, outputs in the layer
- TIMEOUT, 15, max cycles in WAIT before error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin layer; sampled in IDLE only
- abort  in  1  cancel the layer immediately
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse: layer complete
- err  out  1  sticky timeout flag; cleared by rst or next accepted start
- in_addr  out  $clog2(NUM_INPUTS)  activation read address
- in_rdata  in  IN_WIDTH  activation data, 1-cycle read latency
- w_addr  out  $clog2(NUM_INPUTS*NUM_NEURONS)  weight address
- w_rdata  in  IN_WIDTH  weight data, 1-cycle latency
- b_addr  out  $clog2(NUM_NEURONS)  bias address
- b_rdata  in  IN_WIDTH  bias data, 1-cycle latency
- nrn_rst  out  1  synchronous clear to the neuron
- nrn_data, nrn_weight, nrn_bias  out  IN_WIDTH each  combinational pass-through of in_rdata, w_rdata, b_rdata
- nrn_valid  out  1  neuron input_valid
- nrn_out  in  16  neuron data_out
- nrn_out_valid  in  1  neuron out_valid
- res_we  out  1  result write enable
- res_addr  out  $clog2(NUM_NEURONS)  result index
- res_data  out  16  result word

Behaviour:
- Reset: state=IDLE; all outputs 0 (busy, done, err, nrn_rst, nrn_valid, res_we, addresses, res_data). Counters i (input) and n (neuron) = 0.
- States and transitions:
  - IDLE: on start → CLEAR; clears err, i=0, n=0.
  - CLEAR: nrn_rst=1 for exactly one cycle → STREAM.
  - STREAM: per cycle, in_addr=i, w_addr=n*NUM_INPUTS+i, b_addr=n; i++. After i=NUM_INPUTS-1 → WAIT, i=0.
  - WAIT: waits for nrn_out_valid, then registers res_we=1, res_addr=n, res_data=nrn_out (visible the next cycle).
    - If n<NUM_NEURONS-1: n++, → STREAM.
    - Else → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Read-issue flag: high in every STREAM cycle. nrn_valid is this flag delayed one register, aligned with memory data.
- b_addr is held at n from the first STREAM cycle of neuron n through its WAIT, so nrn_bias is stable on the final beat.
- Timing, start sampled at cycle 0, N=NUM_INPUTS, M=NUM_NEURONS:
  - CLEAR at cycle 1.
  - Neuron n STREAM starts at 2+n(N+2).
  - Its nrn_out_valid arrives at 2+n(N+2)+N+1.
  - Its res_we occurs at 2+(n+1)(N+2).
  - done is coincident with the last res_we at M(N+2)+2.
- Exactly N nrn_valid beats per neuron, contiguous; no gaps.
- Timeout: WAIT counter exceeds TIMEOUT without nrn_out_valid → err=1, nrn_rst pulse, → IDLE. No done, no res_we.
- abort: highest priority in any non-IDLE state.
  - Next cycle: state=IDLE, nrn_rst=1 for one cycle, nrn_valid=0, res_we=0.
  - No done; err unchanged.
  - abort in IDLE is a no-op.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- nrn_out_valid outside WAIT is ignored (no write).
- Address arithmetic: unsigned, width per port. No wrap occurs within legal parameter ranges.

Decomposition:
- Shared package (nn_pkg):
  - state enum IDLE/CLEAR/STREAM/WAIT/DONE
  - address-width functions
  - RESULT_WIDTH=16
- Optional sub-module nls_addr_gen holds the i/n counters and w_addr base, with the base accumulated by +NUM_INPUTS per neuron instead of a multiply.

Test Plan:
- NUM_INPUTS=4, NUM_NEURONS=3, memory model with in=[1,2,3,4], weights n-dependent → nrn_valid high 4 contiguous cycles per neuron; res_we at cycles 8, 14, 20 with res_addr 0, 1, 2; done at cycle 20.
- Check w_addr sequence 0..3, 4..7, 8..11 and b_addr held at 0/1/2 → match; nrn_bias equals bias[n] on every final beat.
- abort asserted during neuron 1 STREAM → IDLE next cycle, nrn_rst one pulse, no further res_we, no done; a new start then completes normally.
- Neuron stub that never asserts nrn_out_valid → err=1 after TIMEOUT+1 WAIT cycles, busy=0; err cleared by the next start.
- start pulsed while busy, plus spurious nrn_out_valid during STREAM → no restart, no extra writes, total 3 writes.
- Async rst asserted mid-STREAM without a clock edge → all outputs 0 immediately, state IDLE.
